// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer for a bank of four DW-bit registers.
// Define DFFBANK_LOCK_EN to let a granted requester hold the bank across back-to-back writes.
module dff_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_i,
  input  logic [2*NREQ-1:0]    addr_i,
  input  logic [DW*NREQ-1:0]   data_i,
  input  logic [NREQ-1:0]      lock_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      ack_o,
  output logic                 busy_o,
  output logic [DW*NREQ-1:0]   q_o
);

  typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;

  state_t         state;
  logic [1:0]     last;
  logic [1:0]     winner;
  logic [1:0]     latAddr;
  logic [DW-1:0]  latData;
  logic [DW-1:0]  bank [NREQ];
  logic [1:0]     pick;
  logic [1:0]     cand;
  logic           lockHit;

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Scan downward so the closest requester after last wins; last itself ranks lowest.
  always_comb begin
    pick = last;
    cand = last;
    for (int k = NREQ; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req_i[cand]) pick = cand;
    end
  end

`ifdef DFFBANK_LOCK_EN
  assign lockHit = lock_i[winner] & req_i[winner];
`else
  logic unusedLock;
  assign unusedLock = ^lock_i;
  assign lockHit = 1'b0;
`endif

  always_comb begin
    q_o = '0;
    for (int k = 0; k < NREQ; k++) q_o[k*DW +: DW] = bank[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt_o   <= '0;
      ack_o   <= '0;
      busy_o  <= 1'b0;
      last    <= 2'd3;
      winner  <= 2'd0;
      latAddr <= 2'd0;
      latData <= '0;
      for (int k = 0; k < NREQ; k++) bank[k] <= '0;
    end else begin
      ack_o <= '0;
      case (state)
        IDLE: begin
          if (|req_i) begin
            winner <= pick;
            last   <= pick;
            gnt_o  <= onehot(pick);
            state  <= GRANT;
            busy_o <= 1'b1;
          end else begin
            gnt_o  <= '0;
            busy_o <= 1'b0;
          end
        end
        GRANT: begin
          latAddr <= addr_i[int'(winner)*2 +: 2];
          latData <= data_i[int'(winner)*DW +: DW];
          state   <= WRITE;
          busy_o  <= 1'b1;
        end
        WRITE: begin
          bank[latAddr] <= latData;
          ack_o         <= onehot(winner);
          // A lock keeps the grant and skips arbitration, so last stays put.
          if (lockHit) begin
            state  <= GRANT;
            busy_o <= 1'b1;
          end else begin
            state  <= IDLE;
            gnt_o  <= '0;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          gnt_o  <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed scoreboard bench for dff_bank_arbiter: expected winners are queued as
// requests are driven and checked when the grant/ack appear.
module tb_dff_bank_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  addr;
  logic [31:0] data;
  logic [3:0]  lock;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        busy;
  logic [31:0] q;

  int nAssert = 0;
  int nFail = 0;
  int cycle = 0;
  int ackCycle = 0;
  int expQ[$];
  logic [7:0] model [4];

  dff_bank_arbiter #(.NREQ(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .data_i(data),
    .lock_i(lock), .gnt_o(gnt), .ack_o(ack), .busy_o(busy), .q_o(q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  function automatic logic [31:0] modelQ();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
    req = r;
    lock = l;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    req = 4'b0;
    lock = 4'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) model[k] = 8'h00;
  endtask

  // Pops the next expected winner, then checks its grant, its ack and the bank.
  task automatic serveOne(input string tag);
    int who;
    int n;
    logic [3:0] oh;
    who = expQ.pop_front();
    oh = 4'b0001 << who;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == 4'b0 && n < 12);
    checkOutput({tag, "_gnt"}, {28'b0, gnt}, {28'b0, oh});
    n = 0;
    do begin @(negedge clk); n++; end while (ack == 4'b0 && n < 12);
    checkOutput({tag, "_ack"}, {28'b0, ack}, {28'b0, oh});
    ackCycle = cycle;
    model[addr[2*who +: 2]] = data[8*who +: 8];
    checkOutput({tag, "_q"}, q, modelQ());
  endtask

  initial begin
    int a1;
    int a2;
    int gap;
    rst = 1'b1;
    req = 4'b0;
    lock = 4'b0;
    addr = 8'h00;
    data = 32'h0;
    for (int k = 0; k < 4; k++) model[k] = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", {28'b0, gnt}, 32'h0);
    checkOutput("rst_ack", {28'b0, ack}, 32'h0);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_q", q, 32'h0);
    rst = 1'b0;

    // Single request with exact latency.
    addr = 8'h02;
    data = 32'h0000_00A5;
    applyStimulus(4'b0001, 4'b0000);
    @(negedge clk);
    checkOutput("single_gnt", {28'b0, gnt}, 32'h1);
    checkOutput("single_busy", {31'b0, busy}, 32'h1);
    @(negedge clk);
    checkOutput("single_ack_early", {28'b0, ack}, 32'h0);
    @(negedge clk);
    checkOutput("single_ack", {28'b0, ack}, 32'h1);
    checkOutput("single_q", q, 32'h00A5_0000);
    model[2] = 8'hA5;
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("single_ack_pulse", {28'b0, ack}, 32'h0);
    checkOutput("single_idle_busy", {31'b0, busy}, 32'h0);

    // Round-robin fairness from reset.
    applyReset();
    addr = 8'h1B;
    data = 32'h4433_2211;
    expQ = {0, 1, 2, 3, 0};
    applyStimulus(4'b1111, 4'b0000);
    for (int i = 0; i < 5; i++) serveOne($sformatf("rr%0d", i));
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("rr_final_q", q, 32'h1122_3344);

    // Priority resumes after the last winner.
    expQ.push_back(2);
    applyStimulus(4'b0100, 4'b0000);
    serveOne("pri_r2");
    expQ.push_back(0);
    applyStimulus(4'b0101, 4'b0000);
    serveOne("pri_wrap0");
    expQ.push_back(2);
    applyStimulus(4'b0100, 4'b0000);
    serveOne("pri_r2b");
    applyStimulus(4'b0000, 4'b0000);

    // Reset during WRITE drops the write.
    addr = 8'h04;
    data = 32'h0000_5A00;
    applyStimulus(4'b0010, 4'b0000);
    @(negedge clk);
    checkOutput("mid_gnt", {28'b0, gnt}, 32'h2);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("mid_ack", {28'b0, ack}, 32'h0);
    checkOutput("mid_q", q, 32'h0);
    checkOutput("mid_gnt_clr", {28'b0, gnt}, 32'h0);
    checkOutput("mid_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) model[k] = 8'h00;
    @(negedge clk);
    checkOutput("mid_ack_after", {28'b0, ack}, 32'h0);

    // Lock behaviour (or plain alternation when locking is compiled out).
    addr = 8'h09;
    data = 32'h0000_3CC3;
`ifdef DFFBANK_LOCK_EN
    expQ = {0, 0, 0, 1};
    gap = 2;
`else
    expQ = {0, 1, 0, 1};
    gap = 3;
`endif
    applyStimulus(4'b0011, 4'b0001);
    serveOne("lk1");
    a1 = ackCycle;
    serveOne("lk2");
    a2 = ackCycle;
    checkOutput("lk_gap12", a2 - a1, gap);
    applyStimulus(4'b0011, 4'b0000);
    serveOne("lk3");
    checkOutput("lk_gap23", ackCycle - a2, gap);
    serveOne("lk_after");
    applyStimulus(4'b0000, 4'b0000);

    // Requester 1 drops req during GRANT; its write still lands.
    addr = 8'h0C;
    data = 32'h0000_7700;
    applyStimulus(4'b0010, 4'b0000);
    @(negedge clk);
    checkOutput("drop_gnt", {28'b0, gnt}, 32'h2);
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("drop_ack", {28'b0, ack}, 32'h2);
    model[3] = 8'h77;
    checkOutput("drop_q", q, modelQ());

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin arbiter and write sequencer for a shared bank of four 8-bit D-flip-flop registers. Up to four requesters compete for the bank's single write port. The arbiter picks one requester, latches its address and data, writes the selected register, and returns a one-cycle acknowledge. All register contents are continuously readable on a flat output bus.

## Interface
- NREQ, 4, number of requesters (fixed; other values unsupported)
- DW, 8, register data width
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_i  input  4  request per requester; held high until matching ack
- addr_i  input  8  requester n's target register index in bits [2n+1:2n]
- data_i  input  32  requester n's write data in bits [8n+7:8n]
- lock_i  input  4  bus-lock request per requester (see Configuration)
- gnt_o  output  4  one-hot grant, registered
- ack_o  output  4  one-hot, one-cycle write-complete pulse
- busy_o  output  1  high in any state except IDLE
- q_o  output  32  bank contents; register k occupies bits [8k+7:8k]

## Operation
- State machine has three states: IDLE, GRANT and WRITE.
- IDLE:
  - If req_i is nonzero, select the winner by round-robin and go to GRANT.
  - The search starts at last+1 mod 4 and takes the first set req bit.
  - Set gnt_o to the winner (one-hot) and update last to the winner.
  - Otherwise stay in IDLE with gnt_o=0.
- GRANT:
  - Latch the winner's addr and data slices into internal registers.
  - Go to WRITE.
- WRITE:
  - Write latched data into bank[latched addr].
  - Pulse ack_o[winner] for this cycle.
  - Clear gnt_o on the next edge and return to IDLE, unless the lock rule applies.
- Requesters must hold addr/data stable from req rise until ack; the arbiter samples them in GRANT.
- If a granted requester drops req before WRITE, the write still completes with the latched values and the ack still pulses.
- req_i bits for requesters not granted are ignored until the next IDLE arbitration.
- q_o is the bank itself, a combinational view of the registers. A write becomes visible on q_o the cycle after WRITE.

## Timing
- Reset values:
  - state=IDLE, gnt_o=0, ack_o=0, busy_o=0.
  - bank all zero, so q_o=0.
  - last=3, so requester 0 has first priority after reset.
- Latency from req rise (sampled in IDLE) to the cycles that follow:
  - gnt_o is valid 1 cycle later.
  - ack_o pulses 3 cycles later (IDLE→GRANT→WRITE; ack_o is registered out of WRITE).
  - The bank is updated on the same edge on which ack_o asserts.
- Throughput is one write per 3 cycles without lock, and one per 2 cycles under lock (GRANT→WRITE→GRANT).
- Simultaneous requests: round-robin order guarantees every continuously requesting agent is served within 4 grants.
- If rst is asserted mid-operation, everything returns to the reset values on that edge and any in-flight write is dropped with no ack.
- busy_o is a registered decode of state.

## Configuration
- DFFBANK_LOCK_EN defined:
  - Check the lock rule at WRITE. The lock applies if lock_i[winner] and req_i[winner] are both high at WRITE.
  - When the lock applies, the next state is GRANT with the same winner and gnt_o stays asserted, skipping IDLE and arbitration.
  - last is not advanced while locked.
- DFFBANK_LOCK_EN undefined:
  - lock_i is present but ignored.
  - WRITE always returns to IDLE.

## Test plan
- Reset, then single request: assert rst for 2 cycles, then req_i=0001, addr0=2, data0=8'hA5. Required: gnt_o=0001 one cycle later, ack_o[0] pulses 3 cycles after req, then q_o[23:16]=A5 with all other q_o bits 0.
- Round-robin fairness: hold req_i=1111 with distinct addr/data per requester. Required: grants in order 0,1,2,3,0 and each ack matches its gnt.
- Priority resumes after the last winner: serve requester 2, then assert req_i=0101. Required: requester 0 is granted next (search starts at 3 and wraps).
- Mid-operation reset: assert rst during WRITE. Required: no ack, q_o=0, gnt_o=0 and busy_o=0 on the next cycle.
- Lock (with DFFBANK_LOCK_EN): req_i=0011 and lock_i=0001 held for 3 writes by requester 0. Required: three consecutive ack_o[0] pulses 2 cycles apart. After lock drops, requester 1 is granted next. Without the macro, the same stimulus alternates 0,1,0.
- Requester dropout: requester 1 deasserts req during GRANT. Required: the write still lands in the bank and ack_o[1] still pulses.
